stego_decode: RTL
=================

Name: stego_decode

Overview:
- Reads a 64x64 RGB image that `process` has already written, one pixel at a time through the `image` row/col/in_pix port.
- Recovers the hidden message, which is stored as one bit per pixel in the LSB of the green channel.
- Streams the recovered characters out over a valid/ready handshake and also assembles the whole message into a wide string register.
- It is the receiver for the encoder's output and sits beside `process`, sharing the `image` read port.

Parameters:
- STRING_LEN, 512, number of characters to decode. Legal range is 1..512; 512 x 8 bits = 4096 pixels.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins decoding; sampled only in IDLE or DONE.
- in_pix  input  24  pixel from `image`: [23:16]=R, [15:8]=G, [7:0]=B. Valid one cycle after row/col are presented.
- row  output  6  image row address.
- col  output  6  image column address.
- char_out  output  8  decoded character.
- char_valid  output  1  char_out holds a character.
- char_ready  input  1  consumer accepts char_out.
- hidden_string  output  8*STRING_LEN  decoded message. First character is in bits [8*STRING_LEN-1 -: 8].
- busy  output  1  high from start acceptance until DONE.
- decode_done  output  1  high while in DONE.

Behaviour:
- Reset: state=IDLE; row=0, col=0, char_out=0, char_valid=0, hidden_string=0, busy=0, decode_done=0. Reset overrides everything, including a decode in progress; no partial output survives.
- Pixel order: raster, pixel index p = row*64 + col. col increments first and wraps 63->0 with row+1.
- Bit mapping: message bit k = in_pix[8] of pixel k. Bit k goes to character k/8, bit position 7-(k mod 8), so the MSB comes first.
- States:
  - IDLE: a start pulse clears hidden_string, sets row=col=0 and busy=1, and moves to ADDR.
  - ADDR: row/col are stable this cycle; go to SAMPLE.
  - SAMPLE: shift in_pix[8] into the byte shift register and advance row/col.
    - If 8 bits are now collected: write the byte into its hidden_string slot, drive char_out, set char_valid=1, go to EMIT.
    - Otherwise go to ADDR.
  - EMIT: char_out and char_valid are held stable.
    - A transfer occurs on a clock edge where char_valid && char_ready.
    - After the transfer, char_valid=0. If the last character was sent, go to DONE; otherwise go to ADDR.
    - While char_ready=0 the block stalls indefinitely; row/col do not advance.
  - DONE: decode_done=1, busy=0. hidden_string holds the message until the next start. A start pulse re-enters ADDR exactly as from IDLE.
- start while busy (ADDR/SAMPLE/EMIT) is ignored.
- Timing with char_ready tied high: 2 cycles per bit plus 1 EMIT cycle, i.e. 17 cycles per character.
  - First char_valid rises 16 cycles after the start edge.
  - decode_done rises 17*STRING_LEN cycles after the start edge.
- Pixels beyond 8*STRING_LEN are never addressed. With STRING_LEN=512 the last address read is row=63, col=63, and row/col then wrap to 0.
- Only in_pix[8] is used; all other pixel bits are ignored.

Optional Feature:
- Macro: STEGO_NUL_STOP_EN.
- Defined:
  - A decoded byte equal to 8'h00 ends decoding.
  - That NUL is written to hidden_string (value 0) but is not emitted: char_valid stays 0 and the FSM goes directly SAMPLE->DONE.
  - All remaining hidden_string bytes stay 0.
- Not defined: exactly STRING_LEN characters are always decoded and emitted, NUL bytes included.

Test Plan:
1. STRING_LEN=4; image G-LSBs encode "Ab" followed by two NULs; char_ready=1; macro off.
   -> char_out sequence 8'h41, 8'h62, 8'h00, 8'h00.
   -> hidden_string = 32'h41620000.
   -> decode_done rises exactly 68 cycles after the start edge.
2. Same image, STEGO_NUL_STOP_EN defined.
   -> only 8'h41 and 8'h62 are emitted.
   -> decode_done rises 50 cycles after start (17+17+16).
   -> hidden_string = 32'h41620000.
3. Backpressure: char_ready held 0 for 10 cycles during the first EMIT.
   -> char_out = 8'h41 and char_valid stay stable, row/col hold at pixel 8 (row=0, col=8).
   -> total latency grows by exactly 10 cycles.
4. Reset mid-operation: assert rst in SAMPLE of character 2, then pulse start.
   -> all outputs return to reset values the cycle after rst.
   -> the restart decodes from row=0, col=0 and reproduces the scenario 1 output.
5. STRING_LEN=512 with a checkerboard of G-LSBs (1,0,1,0,...).
   -> every character is 8'hAA, and all 4096 pixels are read in raster order.
   -> the final read is row=63, col=63; decode_done is set after 8704 cycles.
6. A start pulse during busy is ignored (sequence unchanged); a start pulse in DONE clears hidden_string and decodes again identically.

Source files
------------

// File: rtl/stego_decode.sv
// Steganographic message decoder: walks the image in raster order, collects the
// green-channel LSB of each pixel MSB-first into bytes, and streams them out.
// Build option: define STEGO_NUL_STOP_EN to end decoding at the first NUL byte.
module stego_decode #(
  parameter int STRING_LEN = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [23:0]             in_pix,
  output logic [5:0]              row,
  output logic [5:0]              col,
  output logic [7:0]              char_out,
  output logic                    char_valid,
  input  logic                    char_ready,
  output logic [8*STRING_LEN-1:0] hidden_string,
  output logic                    busy,
  output logic                    decode_done
);

  localparam int HW = 8 * STRING_LEN;
  localparam int IW = (HW > 1) ? $clog2(HW) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_SAMPLE = 3'd2;
  localparam logic [2:0] S_EMIT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [11:0]   pix_q, pix_d;
  logic [6:0]    shift_q, shift_d;
  logic [7:0]    char_q, char_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic [HW-1:0] hidden_q, hidden_d;

  logic [7:0]    new_byte;
  logic [8:0]    char_idx;
  logic [IW-1:0] slot_lsb;
  logic          unused_pix_bits;

  // Only the green LSB carries message data.
  assign unused_pix_bits = ^{in_pix[23:9], in_pix[7:0]};

  assign new_byte = {shift_q, in_pix[8]};
  assign char_idx = pix_q[11:3];
  // First character lives in the most significant byte of the string.
  assign slot_lsb = IW'((STRING_LEN - 1 - int'(char_idx)) * 8);

  always_comb begin
    state_d  = state_q;
    pix_d    = pix_q;
    shift_d  = shift_q;
    char_d   = char_q;
    valid_d  = valid_q;
    last_d   = last_q;
    hidden_d = hidden_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          hidden_d = '0;
          pix_d    = '0;
          valid_d  = 1'b0;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: state_d = S_SAMPLE;
      S_SAMPLE: begin
        shift_d = new_byte[6:0];
        pix_d   = pix_q + 12'd1;
        if (pix_q[2:0] == 3'd7) begin
          hidden_d[slot_lsb +: 8] = new_byte;
          last_d = (char_idx == 9'(STRING_LEN - 1));
`ifdef STEGO_NUL_STOP_EN
          if (new_byte == 8'h00) begin
            state_d = S_DONE;
          end else begin
            char_d  = new_byte;
            valid_d = 1'b1;
            state_d = S_EMIT;
          end
`else
          char_d  = new_byte;
          valid_d = 1'b1;
          state_d = S_EMIT;
`endif
        end else begin
          state_d = S_ADDR;
        end
      end
      S_EMIT: begin
        if (char_ready) begin
          valid_d = 1'b0;
          state_d = last_q ? S_DONE : S_ADDR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pix_q    <= '0;
      shift_q  <= '0;
      char_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      hidden_q <= '0;
    end else begin
      state_q  <= state_d;
      pix_q    <= pix_d;
      shift_q  <= shift_d;
      char_q   <= char_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      hidden_q <= hidden_d;
    end
  end

  assign row           = pix_q[11:6];
  assign col           = pix_q[5:0];
  assign char_out      = char_q;
  assign char_valid    = valid_q;
  assign hidden_string = hidden_q;
  assign busy          = (state_q == S_ADDR) || (state_q == S_SAMPLE) || (state_q == S_EMIT);
  assign decode_done   = (state_q == S_DONE);

endmodule
